// File: rtl/game_flow_fsm_if.sv
// Signal bundle between the game flow controller and the rest of the game.
// The master side drives keys, ticks and player status; the slave side reports flow state.
interface game_flow_fsm_if;
  logic       frame_tick;
  logic       start_key;
  logic       player1_dead;
  logic       player2_dead;
  logic       player1_at_door;
  logic       player2_at_door;
  logic [2:0] game_state;
  logic       level_reset;
  logic       freeze;
  logic [1:0] dead_who;
  logic [7:0] death_count;

  modport master (
    output frame_tick, start_key,
    output player1_dead, player2_dead,
    output player1_at_door, player2_at_door,
    input  game_state, level_reset, freeze,
    input  dead_who, death_count
  );

  modport slave (
    input  frame_tick, start_key,
    input  player1_dead, player2_dead,
    input  player1_at_door, player2_at_door,
    output game_state, level_reset, freeze,
    output dead_who, death_count
  );
endinterface

// File: rtl/game_flow_fsm.sv
// Top-level game flow: title, play, death animation, game over and win.
// Tracks session deaths and pulses level_reset when a new round starts.
module game_flow_fsm #(
  parameter int DEATH_FRAMES = 60
) (
  input  logic          Clk,
  input  logic          Reset,
  game_flow_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    PLAYING   = 3'd1,
    DYING     = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4
  } state_t;

  localparam logic [7:0] LAST_FRAME = 8'(DEATH_FRAMES - 1);

  state_t     state, state_n;
  logic       start_q;
  logic       start_edge;
  logic       level_reset, lr_n;
  logic [7:0] frame_cnt, cnt_n;
  logic [7:0] death_count, deaths_n;
  logic [1:0] dead_who, who_n;
  logic       any_dead;
  logic       both_door;

  assign start_edge = bus.start_key & ~start_q;
  assign any_dead   = bus.player1_dead | bus.player2_dead;
  assign both_door  = bus.player1_at_door & bus.player2_at_door;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= TITLE;
      start_q     <= 1'b1;
      level_reset <= 1'b0;
      frame_cnt   <= 8'd0;
      death_count <= 8'd0;
      dead_who    <= 2'b00;
    end else begin
      state       <= state_n;
      start_q     <= bus.start_key;
      level_reset <= lr_n;
      frame_cnt   <= cnt_n;
      death_count <= deaths_n;
      dead_who    <= who_n;
    end
  end

  always_comb begin
    state_n  = state;
    lr_n     = 1'b0;
    cnt_n    = frame_cnt;
    deaths_n = death_count;
    who_n    = dead_who;
    case (state)
      TITLE: begin
        if (start_edge) begin
          state_n = PLAYING;
          lr_n    = 1'b1;
        end
      end
      PLAYING: begin
        // Sticky flags from the last round are still set while level_reset clears them.
        if (!level_reset) begin
          if (any_dead) begin
            state_n  = DYING;
            who_n    = {bus.player2_dead, bus.player1_dead};
            cnt_n    = 8'd0;
            deaths_n = (death_count == 8'hFF) ? 8'hFF
                                              : death_count + 8'd1;
          end else if (both_door) begin
            state_n = WIN;
          end
        end
      end
      DYING: begin
        if (bus.frame_tick) begin
          cnt_n = frame_cnt + 8'd1;
          if (frame_cnt == LAST_FRAME)
            state_n = GAME_OVER;
        end
      end
      GAME_OVER: begin
        if (start_edge) begin
          state_n = PLAYING;
          lr_n    = 1'b1;
        end
      end
      WIN: begin
        if (start_edge) begin
          state_n  = TITLE;
          lr_n     = 1'b1;
          deaths_n = 8'd0;
        end
      end
      default: state_n = TITLE;
    endcase
  end

  assign bus.game_state  = state;
  assign bus.level_reset = level_reset;
  assign bus.freeze      = (state != PLAYING) | level_reset;
  assign bus.dead_who    = dead_who;
  assign bus.death_count = death_count;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model of the game rules.
module tb_game_flow_fsm;

  localparam int DF = 3;

  logic Clk = 1'b0;
  logic Reset;
  int   tests  = 0;
  int   failed = 0;

  game_flow_fsm_if bus();

  game_flow_fsm #(.DEATH_FRAMES(DF)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: phase number as the visible game_state value,
  // death animation as a countdown of remaining ticks.
  int m_phase, m_left, m_deaths, m_who, m_lr, m_prev_key;

  task automatic model_next();
    int edge_seen, lr_next;
    if (Reset) begin
      m_phase = 0; m_left = 0; m_deaths = 0;
      m_who = 0; m_lr = 0; m_prev_key = 1;
      return;
    end
    edge_seen = (bus.start_key == 1'b1) && (m_prev_key == 0);
    lr_next = 0;
    if (m_phase == 0 && edge_seen) begin
      m_phase = 1; lr_next = 1;
    end else if (m_phase == 1 && m_lr == 0) begin
      if (bus.player1_dead || bus.player2_dead) begin
        m_phase = 2;
        m_left = DF;
        m_who = 2 * int'(bus.player2_dead) + int'(bus.player1_dead);
        m_deaths = (m_deaths + 1 > 255) ? 255 : m_deaths + 1;
      end else if (bus.player1_at_door && bus.player2_at_door) begin
        m_phase = 4;
      end
    end else if (m_phase == 2 && bus.frame_tick) begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 3;
    end else if (m_phase == 3 && edge_seen) begin
      m_phase = 1; lr_next = 1;
    end else if (m_phase == 4 && edge_seen) begin
      m_phase = 0; lr_next = 1; m_deaths = 0;
    end
    m_lr = lr_next;
    m_prev_key = int'(bus.start_key);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("game_state", 32'(bus.game_state), 32'(m_phase));
    chk("level_reset", 32'(bus.level_reset), 32'(m_lr));
    chk("freeze", 32'(bus.freeze), 32'((m_phase != 1) || (m_lr != 0)));
    chk("dead_who", 32'(bus.dead_who), 32'(m_who));
    chk("death_count", 32'(bus.death_count), 32'(m_deaths));
  endtask

  task automatic step();
    model_next();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic clear_in();
    bus.frame_tick = 0; bus.start_key = 0;
    bus.player1_dead = 0; bus.player2_dead = 0;
    bus.player1_at_door = 0; bus.player2_at_door = 0;
  endtask

  task automatic press();
    bus.start_key = 0; step();
    bus.start_key = 1; step();
    bus.start_key = 0;
  endtask

  task automatic run_ticks();
    for (int i = 0; i < DF; i++) begin
      bus.frame_tick = 1; step();
      bus.frame_tick = 0; step();
    end
  endtask

  initial begin
    Reset = 1;
    clear_in();
    // key held through reset must not start the game
    bus.start_key = 1;
    step(); step();
    Reset = 0;
    step(); step(); step();
    chk("r028_hold", 32'(bus.game_state), 32'd0);
    bus.start_key = 0; step();
    bus.start_key = 1; step();
    chk("r028_play", 32'(bus.game_state), 32'd1);
    chk("r028_lr", 32'(bus.level_reset), 32'd1);
    step();
    chk("r028_lr_off", 32'(bus.level_reset), 32'd0);
    chk("r028_unfreeze", 32'(bus.freeze), 32'd0);
    bus.start_key = 0;

    // single death, animation timing with idle cycles between ticks
    bus.player2_dead = 1; step();
    bus.player2_dead = 0;
    chk("r029_dying", 32'(bus.game_state), 32'd2);
    chk("r029_who", 32'(bus.dead_who), 32'd2);
    chk("r029_count", 32'(bus.death_count), 32'd1);
    step(); step();
    chk("r029_notick", 32'(bus.game_state), 32'd2);
    run_ticks();
    chk("r029_over", 32'(bus.game_state), 32'd3);

    // stale sticky flag across the restart
    bus.player1_dead = 1;
    bus.start_key = 1; step();
    chk("r031_lr", 32'(bus.level_reset), 32'd1);
    step();
    bus.player1_dead = 0; bus.start_key = 0;
    step();
    chk("r031_play", 32'(bus.game_state), 32'd1);

    // simultaneous deaths and doors
    bus.player1_dead = 1; bus.player2_dead = 1;
    bus.player1_at_door = 1; bus.player2_at_door = 1;
    step();
    clear_in();
    chk("r030_state", 32'(bus.game_state), 32'd2);
    chk("r030_who", 32'(bus.dead_who), 32'd3);
    chk("r030_count", 32'(bus.death_count), 32'd2);
    run_ticks();

    // saturate the death counter
    for (int d = 0; d < 256; d++) begin
      press(); step();
      bus.player1_dead = 1; step();
      bus.player1_dead = 0;
      run_ticks();
    end
    chk("r032_sat", 32'(bus.death_count), 32'd255);
    press(); step();
    bus.player1_at_door = 1; bus.player2_at_door = 1; step();
    clear_in();
    chk("r032_win", 32'(bus.game_state), 32'd4);
    press();
    chk("r032_title", 32'(bus.game_state), 32'd0);
    chk("r032_clear", 32'(bus.death_count), 32'd0);

    // reset in the middle of the death animation
    press(); step();
    bus.player2_dead = 1; step();
    bus.player2_dead = 0;
    bus.frame_tick = 1; step(); step();
    bus.frame_tick = 0;
    chk("r033_dying", 32'(bus.game_state), 32'd2);
    Reset = 1; step();
    Reset = 0;
    chk("r033_title", 32'(bus.game_state), 32'd0);
    chk("r033_freeze", 32'(bus.freeze), 32'd1);
    chk("r033_count", 32'(bus.death_count), 32'd0);
    chk("r033_who", 32'(bus.dead_who), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 199) == 0);
      bus.start_key = ($urandom_range(0, 3) == 0);
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      bus.player1_dead = ($urandom_range(0, 15) == 0);
      bus.player2_dead = ($urandom_range(0, 15) == 0);
      bus.player1_at_door = ($urandom_range(0, 2) == 0);
      bus.player2_at_door = ($urandom_range(0, 2) == 0);
      step();
    end
    Reset = 0;
    clear_in();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/game_flow_fsm.md
GAME_FLOW_FSM -- requirements
Module: game_flow_fsm

Interface
REQ-001 SHALL have parameter DEATH_FRAMES, default 60, number of frame ticks spent in DYING (legal range 1..256).
REQ-002 SHALL have ports Clk, input, 1, system clock; Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have frame_tick, input, 1, one-cycle pulse per video frame.
REQ-004 SHALL have start_key, input, 1, level-sensitive start/continue key.
REQ-005 SHALL have player1_dead, player2_dead, inputs, 1 each, sticky death flags from the hazard controllers.
REQ-006 SHALL have player1_at_door, player2_at_door, inputs, 1 each, player overlapping its exit door.
REQ-007 SHALL have game_state, output, 3, encoded state: TITLE=0, PLAYING=1, DYING=2, GAME_OVER=3, WIN=4.
REQ-008 SHALL have level_reset, output, 1, one-cycle pulse that clears hazard controllers and respawns players.
REQ-009 SHALL have freeze, output, 1, high when player motion is inhibited.
REQ-010 SHALL have dead_who, output, 2, {player2, player1} death flags latched on DYING entry.
REQ-011 SHALL have death_count, output, 8, deaths this session.

Function
REQ-012 SHALL detect start_edge = start_key & ~start_q, where start_q is start_key registered one cycle.
REQ-013 SHALL apply TITLE transition: start_edge -> PLAYING, with level_reset high in the first PLAYING cycle.
REQ-014 SHALL ignore dead and door inputs in PLAYING while level_reset is high (one-cycle guard for stale sticky flags).
REQ-015 SHALL apply PLAYING transition: player1_dead | player2_dead -> DYING; else player1_at_door & player2_at_door -> WIN.
REQ-016 SHALL give death priority over door when both occur in the same cycle.
REQ-017 SHALL, on DYING entry, latch dead_who from both dead inputs, clear frame_cnt, and increment death_count once, saturating at 255, even if both players died in the same cycle.
REQ-018 SHALL, in DYING, increment the 8-bit frame_cnt on each frame_tick, and move to GAME_OVER on a frame_tick with frame_cnt == DEATH_FRAMES-1.
REQ-019 SHALL apply GAME_OVER transition: start_edge -> PLAYING with level_reset pulse; death_count and dead_who are held until DYING is entered again.
REQ-020 SHALL apply WIN transition: start_edge -> TITLE with level_reset pulse and death_count cleared to 0.
REQ-021 SHALL register level_reset; it SHALL be high for exactly one cycle per qualifying start_edge and low otherwise.
REQ-022 SHALL make freeze combinationally equal to (game_state != PLAYING) | level_reset.
REQ-023 SHALL cause no transition from start_edge in PLAYING or DYING.
REQ-024 SHALL decode any illegal state encoding to TITLE on the next clock.
REQ-025 SHALL ignore frame_tick outside DYING.

Reset
REQ-026 SHALL, while Reset is high at a Clk edge, set game_state=TITLE, frame_cnt=0, death_count=0, dead_who=0, level_reset=0, and start_q=1, so a key held through reset does not start the game.
REQ-027 SHALL let Reset asserted mid-operation in any state override all transitions and give freeze=1 on the following cycle.

Verification
REQ-028 SHALL cover start sequence: Reset, hold start_key=1 through reset release -> stays TITLE; release then press -> PLAYING next cycle, level_reset=1 for exactly one cycle, freeze=0 after.
REQ-029 SHALL cover death timing: DEATH_FRAMES=3, in PLAYING assert player2_dead -> DYING, dead_who=2'b10, death_count=1; third frame_tick -> GAME_OVER next cycle, non-tick cycles do not advance.
REQ-030 SHALL cover simultaneous events: player1_dead, player2_dead, and both at_door high in the same cycle -> DYING (not WIN), dead_who=2'b11, death_count increments by 1.
REQ-031 SHALL cover stale flag guard: GAME_OVER with player1_dead still 1, start_edge -> PLAYING with level_reset=1; dead held 1 only during that cycle -> remains PLAYING.
REQ-032 SHALL cover win and saturation: force 256 death cycles -> death_count stays 255; then both at_door -> WIN; start_edge -> TITLE, death_count=0.
REQ-033 SHALL cover mid-run reset: Reset pulsed during DYING with frame_cnt=2 -> TITLE, all outputs at reset values, freeze=1.
